y86_mem_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the Y86 processor's fetch requester (read-only) and its memory-stage requester (read/write).
- Sits between the processor datapath and the memory model.
- Sequences one transaction at a time through a request/ack memory handshake.
- Returns completion and error pulses that the processor maps into its status code (SADR on error).
- Fixed priority to data, with a starvation guard for fetch.

---
 rtl/y86_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_y86_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: single-port memory arbiter for the Y86 core.
// Serialises fetch (read-only) and data (read/write) requests onto one
// request/ack memory port. Data has fixed priority; a starvation counter
// lets fetch through after STARVE_LIMIT consecutive data grants.
// Optional build macro Y86_ARB_PERF_EN adds three 32-bit saturating
// performance counters (perf_i_grants, perf_d_grants, perf_i_stall).
module y86_mem_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clock,
  input  logic          reset,
  // fetch requester
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  // data requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  input  logic          mem_err,
  // status
  output logic          busy,
  output logic          owner
`ifdef Y86_ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_i_stall
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int          SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic          grant_d;
  logic          grant_i;

  // Arbitration is only meaningful in IDLE; data wins unless fetch has
  // already been passed over STARVE_LIMIT times in a row.
  assign grant_d = (state == ST_IDLE) && d_req && (!i_req || (starve_cnt < STARVE_MAX));
  assign grant_i = (state == ST_IDLE) && i_req && !grant_d;

  // Main transaction sequencer: IDLE -> WAIT -> RESP -> IDLE.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every branch sees
    // the pre-edge values; reset is synchronous and sampled here.
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      i_done    <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            owner     <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            owner     <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (owner) begin
              d_rdata <= mem_err ? '0 : mem_rdata;
              d_err   <= mem_err;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_err ? '0 : mem_rdata;
              i_err   <= mem_err;
              i_done  <= 1'b1;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Requests are not sampled here; the requester updates its
          // request during this cycle and is re-arbitrated from IDLE.
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Starvation counter: consecutive data grants while fetch is waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef Y86_ARB_PERF_EN
  // Saturating performance counters for grants and fetch stall cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_i_grants <= '0;
      perf_d_grants <= '0;
      perf_i_stall  <= '0;
    end else begin
      if (grant_i && (perf_i_grants != '1)) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d && (perf_d_grants != '1)) perf_d_grants <= perf_d_grants + 32'd1;
      if (i_req && !(busy && !owner) && (perf_i_stall != '1))
        perf_i_stall <= perf_i_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter: randomized scoreboard bench for y86_mem_arbiter.
// Two requester processes issue transactions and push expected responses
// into per-port queues; a monitor pops and compares on each done pulse.
// A grant monitor checks arbitration order and the presented memory fields.
module tb_y86_mem_arbiter;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LIMIT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, i_done, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;
`ifdef Y86_ARB_PERF_EN
  logic [31:0]   perf_i_grants, perf_d_grants, perf_i_stall;
`endif

  y86_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .busy(busy), .owner(owner)
`ifdef Y86_ARB_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants), .perf_i_stall(perf_i_stall)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_wr;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        i_q[$];
  exp_t        d_q[$];
  int          grant_log[$];
  logic [63:0] mem_arr[logic [63:0]];
  logic [63:0] ref_mem[logic [63:0]];
  bit          mem_manual = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial memory contents and the address-error rule of the memory.
  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0], ~a[31:0]};
  endfunction

  function automatic bit is_bad(input logic [63:0] a);
    return a[40];
  endfunction

  // Memory environment: random 0..2 cycle latency, one-cycle ack.
  initial begin : mem_env
    int lat;
    bit active;
    lat = 0; active = 0;
    mem_ack = 0; mem_err = 0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!mem_manual) begin
        mem_ack = 0; mem_err = 0; mem_rdata = '0;
        if (mem_req) begin
          if (!active) begin active = 1; lat = $urandom_range(0, 2); end
          if (lat == 0) begin
            active  = 0;
            mem_ack = 1;
            if (is_bad(mem_addr)) begin
              mem_err   = 1;
              mem_rdata = {$urandom, $urandom};
            end else if (mem_we) begin
              mem_arr[mem_addr] = mem_wdata;
              mem_rdata = {$urandom, $urandom};
            end else begin
              mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
            end
          end else begin
            lat--;
          end
        end else begin
          active = 0;
        end
      end
    end
  end

  // Grant monitor: data first unless fetch has waited through LIMIT data grants.
  initial begin : grant_mon
    logic si, sd, sr, prev, exp_own;
    int   scnt, wait_cnt;
    prev = 0; wait_cnt = 0;
    forever begin
      @(posedge clock);
      si = i_req; sd = d_req; sr = reset; scnt = wait_cnt;
      @(negedge clock);
      if (sr) begin
        wait_cnt = 0;
      end else if (mem_req && !prev) begin
        exp_own = sd && (!si || scnt < LIMIT);
        check("grant_owner", 64'(owner), 64'(exp_own));
        check("grant_busy", 64'(busy), 64'd1);
        if (exp_own) begin
          check("grant_d_addr", mem_addr, d_addr);
          check("grant_d_we", 64'(mem_we), 64'(d_we));
          check("grant_d_wdata", mem_wdata, d_wdata);
        end else begin
          check("grant_i_addr", mem_addr, i_addr);
          check("grant_i_we", 64'(mem_we), 64'd0);
          check("grant_i_wdata", mem_wdata, 64'd0);
        end
        grant_log.push_back(int'(owner));
        if (!si)          wait_cnt = 0;
        else if (exp_own) wait_cnt = (scnt + 1 > LIMIT) ? LIMIT : scnt + 1;
        else              wait_cnt = 0;
      end else if (!si) begin
        wait_cnt = 0;
      end
      prev = mem_req;
    end
  end

  // Response monitor: pops expectations on each done pulse.
  initial begin : resp_mon
    logic pi, pd;
    exp_t e;
    pi = 0; pd = 0;
    forever begin
      @(negedge clock);
      if (i_done && d_done) check("both_done", 64'd1, 64'd0);
      if (i_done) begin
        check("i_done_pulse", 64'(pi), 64'd0);
        check("i_done_owner", 64'(owner), 64'd0);
        if (i_q.size() == 0) check("i_unexpected_done", 64'd1, 64'd0);
        else begin
          e = i_q.pop_front();
          check("i_rdata", i_rdata, e.rdata);
          check("i_err", 64'(i_err), 64'(e.err));
        end
      end
      if (d_done) begin
        check("d_done_pulse", 64'(pd), 64'd0);
        check("d_done_owner", 64'(owner), 64'd1);
        if (d_q.size() == 0) check("d_unexpected_done", 64'd1, 64'd0);
        else begin
          e = d_q.pop_front();
          if (!e.is_wr) check("d_rdata", d_rdata, e.rdata);
          check("d_err", 64'(d_err), 64'(e.err));
        end
      end
      pi = i_done; pd = d_done;
    end
  end

  task automatic do_fetch(input logic [63:0] a);
    exp_t e;
    bit   got;
    e.is_wr = 0;
    e.err   = is_bad(a);
    e.rdata = e.err ? 64'd0 : init_word(a);
    i_q.push_back(e);
    i_addr = a;
    i_req  = 1;
    got    = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (i_done) begin got = 1; break; end
    end
    if (!got) check("fetch_timeout", 64'd1, 64'd0);
    i_req = 0;
  endtask

  task automatic do_data(input logic we, input logic [63:0] a, input logic [63:0] wd);
    exp_t e;
    bit   got;
    e.is_wr = we;
    e.err   = is_bad(a);
    e.rdata = 64'd0;
    if (!we && !e.err) e.rdata = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    if (we && !e.err)  ref_mem[a] = wd;
    d_q.push_back(e);
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1;
    got   = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (d_done) begin got = 1; break; end
    end
    if (!got) check("data_timeout", 64'd1, 64'd0);
    d_req = 0;
  endtask

  function automatic logic [63:0] rand_faddr();
    logic [63:0] a;
    a = 64'h1000 + 64'(8 * $urandom_range(0, 255));
    if ($urandom_range(0, 9) == 0) a[40] = 1'b1;
    return a;
  endfunction

  function automatic logic [63:0] rand_daddr();
    logic [63:0] a;
    a = 64'h200 + 64'(8 * $urandom_range(0, 15));
    if ($urandom_range(0, 9) == 0) a[40] = 1'b1;
    return a;
  endfunction

  task automatic fetch_run(input int n, input int gmax);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gmax)) @(negedge clock);
      do_fetch(rand_faddr());
    end
  endtask

  task automatic data_run(input int n, input int gmax);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gmax)) @(negedge clock);
      do_data(1'($urandom_range(0, 1)), rand_daddr(), {$urandom, $urandom});
    end
  endtask

  initial begin : main
    int exp_seq[6];
    bit got;
    exp_seq = '{1, 1, 0, 1, 1, 0};
    reset = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_i_done", 64'(i_done), 64'd0);
    check("rst_d_done", 64'(d_done), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    reset = 0;
    @(negedge clock);

    // Directed: fetch, data write/read-back, address error then recovery.
    do_fetch(64'h100);
    do_data(1'b1, 64'h200, 64'hDEADBEEF);
    do_data(1'b0, 64'h200, 64'd0);
    do_data(1'b0, 64'h100_0000_0208, 64'd0);
    do_data(1'b0, 64'h200, 64'd0);

    // Directed: simultaneous back-to-back requests give D, D, I, D, D, I.
    repeat (2) @(negedge clock);
    grant_log.delete();
    fork
      data_run(4, 0);
      fetch_run(2, 0);
    join
    check("starve_seq_len", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check("starve_seq", 64'(grant_log[k]), 64'(exp_seq[k]));

    // Randomized mixed traffic.
    fork
      fetch_run(40, 3);
      data_run(60, 3);
    join

    // Reset while a fetch is in WAIT; the late ack must be ignored.
    repeat (2) @(negedge clock);
    mem_manual = 1;
    mem_ack = 0; mem_err = 0;
    i_addr = 64'h1008; i_req = 1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (mem_req) begin got = 1; break; end
    end
    check("wait_mem_req_seen", 64'(got), 64'd1);
    reset = 1;
    @(negedge clock);
    reset = 0; i_req = 0;
    mem_ack = 1; mem_rdata = 64'h1234; mem_err = 0;
    check("rstwait_mem_req", 64'(mem_req), 64'd0);
    check("rstwait_busy", 64'(busy), 64'd0);
    @(negedge clock);
    mem_ack = 0; mem_rdata = '0;
    check("late_ack_i_done", 64'(i_done), 64'd0);
    check("late_ack_d_done", 64'(d_done), 64'd0);
    check("late_ack_busy", 64'(busy), 64'd0);
    check("late_ack_mem_req", 64'(mem_req), 64'd0);
    mem_manual = 0;
    do_fetch(64'h1010);

    repeat (4) @(negedge clock);
    check("i_queue_empty", 64'(i_q.size()), 64'd0);
    check("d_queue_empty", 64'(d_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
